// File: rtl/serial_tx_parity.sv
// Byte-wide serial transmitter: start, 8 data bits LSB first, odd parity, stop, then GAP_BITS idle bits.
// Optional one-entry pending register is compiled in with `define SERIAL_TX_BUF_EN.
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | start bit (0) on the line
// DATA   | data bit bit_idx_q on the line
// PARITY | odd-parity bit on the line
// STOP   | stop bit (1) on the line, o_done high
// GAP    | idle-high spacing after the stop bit
module serial_tx_parity #(
  parameter int unsigned GAP_BITS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic       o_data,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } state_t;

  localparam logic [3:0] GAP_LOAD = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       data_q, data_d;
  logic       done_q, done_d;
  logic       accept;
  logic       frame_end;

`ifdef SERIAL_TX_BUF_EN
  logic [7:0] pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;

  assign o_ready = !pend_vld_q;
`else
  assign o_ready = (state_q == IDLE);
`endif

  assign accept = i_valid && o_ready;
  assign o_data = data_q;
  assign o_done = done_q;
  assign o_busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = 1'b1;
    done_d    = 1'b0;
    frame_end = 1'b0;
`ifdef SERIAL_TX_BUF_EN
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
`endif

    // data_d is the bit the line will carry in the cycle belonging to state_d
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = i_byte;
          data_d  = 1'b0;
        end
      end
      START: begin
        state_d   = DATA;
        bit_idx_d = 3'd0;
        data_d    = shift_q[0];
      end
      DATA: begin
        if (bit_idx_q == 3'd7) begin
          state_d   = PARITY;
          bit_idx_d = 3'd0;
          data_d    = ~^shift_q;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          data_d    = shift_q[bit_idx_q + 3'd1];
        end
      end
      PARITY: begin
        state_d = STOP;
        done_d  = 1'b1;
      end
      STOP: begin
        if (GAP_BITS > 0) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          frame_end = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          frame_end = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SERIAL_TX_BUF_EN
    // A byte arriving in the last busy cycle goes straight into the next frame.
    if (frame_end) begin
      if (pend_vld_q) begin
        state_d    = START;
        shift_d    = pend_q;
        pend_vld_d = 1'b0;
        data_d     = 1'b0;
      end else if (accept) begin
        state_d = START;
        shift_d = i_byte;
        data_d  = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end else if (accept && (state_q != IDLE)) begin
      pend_d     = i_byte;
      pend_vld_d = 1'b1;
    end
`else
    if (frame_end) begin
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      gap_cnt_q <= 4'd0;
      data_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

`ifdef SERIAL_TX_BUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 8'h00;
      pend_vld_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end
`endif

`ifndef SYNTHESIS
  a_done_on_stop : assert property (@(posedge clk) disable iff (!rst_n) o_done |-> o_data);
  a_idle_high    : assert property (@(posedge clk) disable iff (!rst_n) !o_busy |-> o_data);
`endif

endmodule
